// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage with a DEPTH-entry in-order buffer,
//                valid/ready request channel and valid-only response channel.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      r_fetch_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_started;
    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [DEPTH-1:0] r_filled;

    logic [CNT_W:0]   w_inflight;
    logic             w_accept;
    logic             w_pop;
    logic             w_drop;
    logic             w_fill;
    logic [PTR_W-1:0] w_fill_idx;
    logic [31:0]      w_redirect_pc;

    assign w_redirect_pc  = redirect_pc & ~32'h0000_0003;
    assign w_inflight     = {1'b0, r_occ} + {1'b0, r_drop_cnt};

    // Issue waits one clock after reset so requests start on a clean edge.
    assign imem_req_valid = r_started && !redirect_valid
                            && (w_inflight < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign if_valid       = r_filled[r_head] && !redirect_valid;
    assign if_pc          = (r_occ != '0) ? r_pc[r_head]    : 32'h0;
    assign if_instruction = (r_occ != '0) ? r_instr[r_head] : 32'h0;
    assign w_pop          = if_valid && !stall;

    // Filled entries are always contiguous from the head, so the oldest
    // unfilled slot sits just past them.
    assign w_fill_idx     = r_head + PTR_W'(r_occ - r_pending);
    assign w_drop         = imem_resp_valid && (r_drop_cnt != '0);
    assign w_fill         = imem_resp_valid && (r_drop_cnt == '0) && (r_pending != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_pending  <= '0;
            r_drop_cnt <= '0;
            r_started  <= 1'b0;
            r_filled   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= 32'h0;
                r_instr[i] <= 32'h0;
            end
        end else begin
            r_started <= 1'b1;
            if (redirect_valid) begin
                // Every outstanding request still owes a response; a response
                // arriving now settles one of them.
                r_drop_cnt <= r_drop_cnt + r_pending - CNT_W'(imem_resp_valid);
                r_head     <= '0;
                r_tail     <= '0;
                r_occ      <= '0;
                r_pending  <= '0;
                r_filled   <= '0;
                r_fetch_pc <= w_redirect_pc;
            end else begin
                if (w_accept) begin
                    r_pc[r_tail]    <= r_fetch_pc;
                    r_instr[r_tail] <= 32'h0;
                    r_tail          <= r_tail + PTR_W'(1);
                    r_fetch_pc      <= r_fetch_pc + 32'd4;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
                if (w_fill) begin
                    r_instr[w_fill_idx]  <= imem_resp_data;
                    r_filled[w_fill_idx] <= 1'b1;
                end
                if (w_pop) begin
                    r_filled[r_head] <= 1'b0;
                    r_head           <= r_head + PTR_W'(1);
                end
                r_occ     <= r_occ + CNT_W'(w_accept) - CNT_W'(w_pop);
                r_pending <= r_pending + CNT_W'(w_accept) - CNT_W'(w_fill);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        mem_hold;
    logic [31:0] mem_q [$];

    fetch_unit #(
        .RESET_PC (32'h0000_0100),
        .DEPTH    (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_pc           (if_pc),
        .if_instruction  (if_instruction),
        .if_valid        (if_valid)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory returns addr ^ A5A5_0000 in order; mem_hold withholds responses.
    task automatic tick();
        if (!mem_hold && mem_q.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q.pop_front() ^ 32'hA5A5_0000;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        if (imem_req_valid && imem_req_ready && !reset) mem_q.push_back(imem_req_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (if_valid) begin
                seen = 1'b1;
                check_value({tag, "_pc"}, if_pc, pc);
                check_value({tag, "_instr"}, if_instruction, ins);
            end
            tick();
        end
        if (!seen) check_value({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; mem_hold = 1'b0;
        @(posedge clk); #1;
        check_value("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check_value("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check_value("rst_if_pc", if_pc, 32'h0);
        check_value("rst_if_instr", if_instruction, 32'h0);
        tick();

        // Stream start-up and no-bypass latency
        reset = 1'b0;
        #1;
        check_value("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        check_value("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check_value("first_req_addr", imem_req_addr, 32'h100);
        tick();
        check_value("second_req_addr", imem_req_addr, 32'h104);
        check_value("latency_if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        check_value("first_if_valid", {31'b0, if_valid}, 32'd1);
        expect_word("w100", 32'h100, 32'hA5A5_0100);
        expect_word("w104", 32'h104, 32'hA5A5_0104);
        expect_word("w108", 32'h108, 32'hA5A5_0108);

        // Stall holds the head; buffer fills and issue stops
        stall = 1'b1;
        check_value("stall_pc0", if_pc, 32'h10C);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("stall_pc", if_pc, 32'h10C);
            check_value("stall_instr", if_instruction, 32'hA5A5_010C);
            check_value("stall_valid", {31'b0, if_valid}, 32'd1);
            check_value("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        end
        stall = 1'b0;
        expect_word("w10c", 32'h10C, 32'hA5A5_010C);
        expect_word("w110", 32'h110, 32'hA5A5_0110);
        expect_word("w114", 32'h114, 32'hA5A5_0114);

        // Memory not ready: address held, nothing allocated
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("nrdy_addr", imem_req_addr, 32'h11C);
            check_value("nrdy_req_valid", {31'b0, imem_req_valid}, 32'd1);
        end
        check_value("nrdy_if_valid", {31'b0, if_valid}, 32'd0);
        check_value("nrdy_empty_pc", if_pc, 32'h0);
        check_value("nrdy_empty_instr", if_instruction, 32'h0);
        imem_req_ready = 1'b1;
        expect_word("w11c", 32'h11C, 32'hA5A5_011C);

        // Two in flight, then redirect: both late responses dropped
        mem_hold = 1'b1;
        tick();
        tick();
        check_value("inflight_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check_value("inflight_if_valid", {31'b0, if_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        check_value("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0; mem_hold = 1'b0;
        check_value("drain_block_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        check_value("drain_resume_req", {31'b0, imem_req_valid}, 32'd1);
        check_value("drain_resume_addr", imem_req_addr, 32'h200);
        expect_word("w200", 32'h200, 32'hA5A5_0200);
        expect_word("w204", 32'h204, 32'hA5A5_0204);

        // Misaligned redirect near the top of memory, then wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        #1;
        check_value("redir_if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        check_value("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        expect_word("wfffc", 32'hFFFF_FFFC, 32'h5A5A_FFFC);
        expect_word("w000", 32'h0, 32'hA5A5_0000);

        // Asynchronous reset with requests outstanding
        mem_hold = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_value("arst_if_valid", {31'b0, if_valid}, 32'd0);
        check_value("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check_value("arst_if_pc", if_pc, 32'h0);
        mem_q.delete();
        mem_hold = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check_value("rel_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        check_value("restart_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check_value("restart_addr", imem_req_addr, 32'h100);
        expect_word("rw100", 32'h100, 32'hA5A5_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
